// File: rtl/design_select_ctrl.sv
// Wishbone-controlled selector that holds nine designs in reset and releases one after a programmable delay.
// Optional CTRL[31] write lock is compiled in with `define DSC_WRITE_LOCK_EN.
module design_select_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [15:0] RESET_DELAY = 16'd16
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [8:0]  design_rst_n,
  output logic [31:0] custom_settings,
  output logic [3:0]  active_design,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ack;
  logic [3:0]  r_sel;
  logic        r_en;
  logic        r_err;
  logic        r_irq_pend;
  logic [31:0] r_settings;
  logic [15:0] r_delay;
  logic [15:0] r_cnt;
  logic [8:0]  r_design_rst_n;
  logic [31:0] r_custom;
  logic [3:0]  r_active;

  logic        w_hit;
  logic        w_wr;
  logic        w_lock;
  logic        w_ctrl_wr;
  logic        w_set_wr;
  logic        w_stat_wr;
  logic        w_dly_wr;
  logic [3:0]  w_new_sel;
  logic        w_new_en;
  logic        w_new_valid;
  logic [31:0] w_settings_new;
  logic [15:0] w_delay_new;
  logic [3:0]  w_stat_design;
  logic [31:0] w_rdata;
  logic        w_unused_adr;

  assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Classic cycle: the master holds the request through the ack cycle, so the write commits on its closing edge.
  assign w_wr      = r_ack & w_hit & wbs_we_i;
  assign w_ctrl_wr = w_wr & (wbs_adr_i[3:2] == 2'd0) & ~w_lock;
  assign w_set_wr  = w_wr & (wbs_adr_i[3:2] == 2'd1) & ~w_lock;
  assign w_stat_wr = w_wr & (wbs_adr_i[3:2] == 2'd2);
  assign w_dly_wr  = w_wr & (wbs_adr_i[3:2] == 2'd3) & ~w_lock;
  assign w_unused_adr = ^wbs_adr_i[1:0];

  assign w_new_sel   = wbs_sel_i[0] ? wbs_dat_i[3:0] : r_sel;
  assign w_new_en    = wbs_sel_i[0] ? wbs_dat_i[4]   : r_en;
  assign w_new_valid = (w_new_sel <= 4'd8);
  assign w_delay_new = {wbs_sel_i[1] ? wbs_dat_i[15:8] : r_delay[15:8],
                        wbs_sel_i[0] ? wbs_dat_i[7:0]  : r_delay[7:0]};

  always_comb begin
    w_settings_new = r_settings;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) w_settings_new[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end

`ifdef DSC_WRITE_LOCK_EN
  logic r_lock;
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)                                        r_lock <= 1'b0;
    else if (w_ctrl_wr && wbs_sel_i[3] && wbs_dat_i[31]) r_lock <= 1'b1;
  end
  assign w_lock = r_lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_stat_design = (r_state == ST_RUN) ? r_sel : 4'h0;

  always_comb begin
    w_rdata = '0;
    if (r_ack) begin
      case (wbs_adr_i[3:2])
        2'd0:    w_rdata = {w_lock, 26'd0, r_en, r_sel};
        2'd1:    w_rdata = r_settings;
        2'd2:    w_rdata = {23'd0, r_irq_pend, w_lock, r_err, w_stat_design, r_state};
        default: w_rdata = {16'd0, r_delay};
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ack          <= 1'b0;
      r_sel          <= '0;
      r_en           <= 1'b0;
      r_err          <= 1'b0;
      r_irq_pend     <= 1'b0;
      r_settings     <= '0;
      r_delay        <= RESET_DELAY;
      r_cnt          <= '0;
      r_design_rst_n <= '0;
      r_custom       <= '0;
      r_active       <= 4'hF;
    end else begin
      r_ack <= w_hit & ~r_ack;
      if (w_set_wr) r_settings <= w_settings_new;
      if (w_dly_wr) r_delay    <= w_delay_new;
      if (w_stat_wr && wbs_sel_i[1] && wbs_dat_i[8]) r_irq_pend <= 1'b0;

      // A CTRL write overrides the sequencer from any state; the RUN-entry set below must follow the clear above.
      if (w_ctrl_wr) begin
        r_sel          <= w_new_sel;
        r_en           <= w_new_en;
        r_design_rst_n <= '0;
        r_active       <= 4'hF;
        if (w_new_valid)   r_err <= 1'b0;
        else if (w_new_en) r_err <= 1'b1;
        if (w_new_en && w_new_valid) begin
          r_state  <= ST_HOLD;
          r_cnt    <= r_delay;
          r_custom <= r_settings;
        end else begin
          r_state <= ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_cnt == 16'd0) begin
              r_state        <= ST_RUN;
              r_design_rst_n <= 9'd1 << r_sel;
              r_active       <= r_sel;
              r_irq_pend     <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o       = r_ack;
  assign wbs_dat_o       = w_rdata;
  assign design_rst_n    = r_design_rst_n;
  assign custom_settings = r_custom;
  assign active_design   = r_active;
  assign irq             = r_irq_pend;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Directed bench for design_select_ctrl: register table plus timed reset-release sequences.
module tb_design_select_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_i = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [8:0]  drst_n;
  logic [31:0] cust;
  logic [3:0]  act;
  logic        irq;

  int checks = 0;
  int errors = 0;

  design_select_ctrl #(.BASE_ADDR(BASE), .RESET_DELAY(16'd16)) dut (
    .wb_clk_i(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .design_rst_n(drst_n), .custom_settings(cust), .active_design(act), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [3:0]  off;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic wb_xfer(input string name, input logic w, input logic [3:0] s,
                         input logic [3:0] off, input logic [31:0] d, output logic [31:0] rd);
    logic seen;
    seen = 1'b0;
    rd = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = BASE | {28'd0, off}; dat_i = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        seen = 1'b1;
        rd = dat_o;
        break;
      end
    end
    chk({name, "_ack"}, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_ack_one_cycle"}, {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input string name, input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    wb_xfer(name, 1'b1, s, off, d, rd);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] expected);
    logic [31:0] rd;
    wb_xfer(name, 1'b0, 4'hF, off, '0, rd);
    chk(name, rd, expected);
  endtask

  // After a transfer has returned (write edge already past), watch n more edges: resets low until the last one.
  task automatic wait_release(input string name, input int n, input logic [8:0] final_val);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_cyc%0d", name, k), {23'd0, drst_n}, (k == n) ? {23'd0, final_val} : 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic seen;

    vecs[0] = '{1'b0, 4'hF, 4'hC, 32'h0,         32'h0000_0010};
    vecs[1] = '{1'b0, 4'hF, 4'h8, 32'h0,         32'h0000_0000};
    vecs[2] = '{1'b0, 4'hF, 4'h0, 32'h0,         32'h0000_0000};
    vecs[3] = '{1'b0, 4'hF, 4'h4, 32'h0,         32'h0000_0000};
    vecs[4] = '{1'b1, 4'hF, 4'h4, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{1'b1, 4'b0101, 4'h4, 32'h0000_0000, 32'h0};
    vecs[6] = '{1'b0, 4'hF, 4'h4, 32'h0,         32'hFF00_FF00};
    vecs[7] = '{1'b1, 4'hF, 4'h4, 32'hA5A5_0003, 32'h0};
    vecs[8] = '{1'b1, 4'hF, 4'hC, 32'h0000_0004, 32'h0};
    vecs[9] = '{1'b0, 4'hF, 4'hC, 32'h0,         32'h0000_0004};

    #12;
    chk("rst_drst", {23'd0, drst_n}, 32'd0);
    chk("rst_cust", cust, 32'd0);
    chk("rst_active", {28'd0, act}, 32'hF);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wr($sformatf("vec%0d_wr", i), vecs[i].off, vecs[i].dat, vecs[i].sel);
      else rd_chk($sformatf("vec%0d_rd", i), vecs[i].off, vecs[i].exp);
    end

    // Out-of-window address must never be acked.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("nohit_ack%0d", k), {31'd0, ack}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0; adr = '0;

    // Start design 3 with DELAY=4.
    wr("ctrl_13", 4'h0, 32'h0000_0013, 4'hF);
    chk("hold_drst", {23'd0, drst_n}, 32'd0);
    wait_release("run3", 5, 9'h008);
    chk("run3_cust", cust, 32'hA5A5_0003);
    chk("run3_irq", {31'd0, irq}, 32'd1);
    chk("run3_active", {28'd0, act}, 32'd3);
    rd_chk("run3_status", 4'h8, 32'h0000_010E);

    // SETTINGS write in RUN is shadow-only until the next HOLD entry.
    wr("set_shadow", 4'h4, 32'h1234_5678, 4'hF);
    chk("shadow_cust", cust, 32'hA5A5_0003);

    // Retarget to design 5 while running.
    wr("ctrl_15", 4'h0, 32'h0000_0015, 4'hF);
    chk("retarget_drst", {23'd0, drst_n}, 32'd0);
    chk("retarget_active", {28'd0, act}, 32'hF);
    wait_release("run5", 5, 9'h020);
    chk("run5_cust", cust, 32'h1234_5678);

    wr("irq_clr", 4'h8, 32'h0000_0100, 4'b0010);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    wr("ctrl_1c", 4'h0, 32'h0000_001C, 4'hF);
    chk("err_drst", {23'd0, drst_n}, 32'd0);
    rd_chk("err_status", 4'h8, 32'h0000_0040);
    wr("ctrl_00", 4'h0, 32'h0000_0000, 4'hF);
    rd_chk("errclr_status", 4'h8, 32'h0000_0000);

    wr("dly_lane0", 4'hC, 32'hFFFF_FFFF, 4'b0001);
    rd_chk("dly_lane0", 4'hC, 32'h0000_00FF);

    // DELAY=0: exactly one HOLD cycle, then the lock / read-as-zero check on CTRL[31].
    wr("dly_zero", 4'hC, 32'h0000_0000, 4'b0011);
    wr("ctrl_lock", 4'h0, 32'h8000_0011, 4'hF);
    wait_release("run1", 1, 9'h002);
`ifdef DSC_WRITE_LOCK_EN
    rd_chk("ctrl_rd_lock", 4'h0, 32'h8000_0011);
    wr("ctrl_12", 4'h0, 32'h0000_0012, 4'hF);
    repeat (3) @(posedge clk);
    #1 chk("locked_drst", {23'd0, drst_n}, 32'h002);
    wr("set_locked", 4'h4, 32'hDEAD_BEEF, 4'hF);
    rd_chk("set_locked", 4'h4, 32'h1234_5678);
`else
    rd_chk("ctrl_rd_nolock", 4'h0, 32'h0000_0011);
    wr("ctrl_12", 4'h0, 32'h0000_0012, 4'hF);
    wait_release("run2", 1, 9'h004);
    wr("set_unlocked", 4'h4, 32'hDEAD_BEEF, 4'hF);
    rd_chk("set_unlocked", 4'h4, 32'hDEAD_BEEF);
`endif
    wr("irq_clr2", 4'h8, 32'h0000_0100, 4'b0010);
    chk("irq_clr2", {31'd0, irq}, 32'd0);

    // Reset asserted during the ack cycle of a SETTINGS write.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE | 32'h4; dat_i = 32'hCAFE_F00D;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin seen = 1'b1; break; end
    end
    chk("midrst_ack_seen", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1 chk("midrst_ack_drop", {31'd0, ack}, 32'd0);
    chk("midrst_drst", {23'd0, drst_n}, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    #2 rst_n = 1'b1;
    rd_chk("midrst_settings", 4'h4, 32'h0000_0000);
    rd_chk("midrst_delay", 4'hC, 32'h0000_0010);
    rd_chk("midrst_ctrl", 4'h0, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/design_select_ctrl.md
DESIGN_SELECT_CTRL -- requirements
Module: design_select_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, base of the 16-byte register window (bits [3:0] ignored).
REQ-002 SHALL have parameter RESET_DELAY, default 16'd16, reset value of the DELAY register.
REQ-003 SHALL have port wb_clk_i, input, 1: sole clock, all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, input, 1 each: Wishbone classic slave strobes.
REQ-006 SHALL have port wbs_sel_i, input, 4: byte lanes.
REQ-007 SHALL have ports wbs_adr_i and wbs_dat_i, input, 32 each: address and write data.
REQ-008 SHALL have port wbs_ack_o, output, 1: transfer acknowledge.
REQ-009 SHALL have port wbs_dat_o, output, 32: read data.
REQ-010 SHALL have port design_rst_n, output, 9: per-design active-low resets, index = design number 0..8.
REQ-011 SHALL have port custom_settings, output, 32: settings bus to designs.
REQ-012 SHALL have port active_design, output, 4: design currently in RUN, 4'hF otherwise.
REQ-013 SHALL have port irq, output, 1: level interrupt.

Function
REQ-014 SHALL decode a hit as cyc&stb with adr[31:4]==BASE_ADDR[31:4]; registers at offsets 0x0 CTRL, 0x4 SETTINGS, 0x8 STATUS, 0xC DELAY.
REQ-015 SHALL assert wbs_ack_o for exactly one cycle, one cycle after a hit, and never on two consecutive cycles.
REQ-016 SHALL apply writes byte-wise per wbs_sel_i on the acking cycle; wbs_dat_o is valid while wbs_ack_o is high, else 0; a non-hit gets no ack.
REQ-017 SHALL define CTRL as [3:0] SEL and [4] EN; SETTINGS as a 32-bit shadow; DELAY as [15:0]; STATUS read-only except [8].
REQ-018 SHALL define STATUS as [1:0] state (IDLE=0, HOLD=1, RUN=2), [5:2] active_design, [6] ERR, [7] LOCK, [8] IRQ_PEND (write-1-to-clear).
REQ-019 SHALL run FSM IDLE: all design_rst_n=0; on EN=1 with SEL<=8, load counter with DELAY, go HOLD; on EN=1 with SEL>8, set ERR and stay IDLE.
REQ-020 SHALL in HOLD keep all resets low, copy SETTINGS into custom_settings on entry, decrement the counter each cycle, and go RUN when it reaches 0 (DELAY=0 gives one HOLD cycle).
REQ-021 SHALL in RUN drive design_rst_n[SEL]=1 and all others 0, and set IRQ_PEND on the entry cycle.
REQ-022 SHALL on any CTRL write while in HOLD or RUN deassert all resets the next cycle and re-enter HOLD (EN=1, valid SEL) or IDLE (otherwise), restarting the counter.
REQ-023 SHALL not change custom_settings on SETTINGS writes outside HOLD entry.
REQ-024 SHALL clear ERR on any CTRL write with a valid SEL.
REQ-025 SHALL drive irq = IRQ_PEND; a set event on the same cycle as a clear wins.

Reset
REQ-026 SHALL on rst_n=0 force IDLE, all registers 0 except DELAY=RESET_DELAY, design_rst_n=9'h000, custom_settings=0, active_design=4'hF, wbs_ack_o=0, irq=0.
REQ-027 SHALL, on reset mid-transfer, drop wbs_ack_o and discard the pending write.

Configuration
REQ-028 SHALL implement CTRL[31] LOCK only when DSC_WRITE_LOCK_EN is defined: once written 1, subsequent CTRL/SETTINGS/DELAY writes are acked but ignored until reset; STATUS[8] clear still works.
REQ-029 SHALL without DSC_WRITE_LOCK_EN treat CTRL[31] as read-as-zero and never lock.

Verification
REQ-030 SHALL cover: reset, then read DELAY -> 0x0000_0010; read STATUS -> 0; design_rst_n=0.
REQ-031 SHALL cover: SETTINGS=0xA5A5_0003, DELAY=4, CTRL=0x13 -> design_rst_n=9'h008 exactly 5 cycles after the CTRL ack; custom_settings=0xA5A5_0003; irq=1; active_design=3.
REQ-032 SHALL cover: in RUN, CTRL=0x15 -> all resets low the next cycle, then design_rst_n=9'h020 after DELAY+1 cycles.
REQ-033 SHALL cover: CTRL=0x1C -> STATUS[6]=1, state IDLE, design_rst_n=0.
REQ-034 SHALL cover: write 0x100 to STATUS -> irq=0; sel=4'b0001 write of 0xFFFF_FFFF to DELAY -> DELAY=0x0000_00FF.
REQ-035 SHALL cover, with DSC_WRITE_LOCK_EN: CTRL=0x8000_0011, then CTRL=0x12 -> ack seen, design_rst_n stays 9'h002.
